grid_cell_buffer: RTL and testbench

Downstream display stage of the A* path-finder. Holds a 40x40 cell-state map (unknown / free / obstacle / path) that the search core writes cell-by-cell over a valid/ready port. A pixel-coordinate port from the VGA timing generator reads the map back as the `draw_grid`, `draw_obstacle`, `draw_path` and `draw_unknown` flags. After reset, and on request, it sweeps the whole map back to "unknown".

---
 rtl/astar_pkg.sv | 38 +++
 rtl/grid_cell_ram.sv | 37 +++
 rtl/grid_cell_buffer.sv | 253 +++++++++++++++++++++++++
 tb/tb_grid_cell_buffer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/astar_pkg.sv
// astar_pkg
// Shared definitions for the A* path-finder display slice: the cell-kind
// encoding, the state machine states, grid geometry constants and the
// cell-address helper used by both the write port and the display pipeline.
package astar_pkg;

  localparam int GRID_W     = 40;
  localparam int GRID_H     = 40;
  localparam int COORD_W    = 6;
  localparam int ADDR_W     = 11;
  localparam int CELL_COUNT = GRID_W * GRID_H;

  // Coordinate reported for pixels that fall outside the map region
  localparam logic [COORD_W-1:0] COORD_OUTSIDE = 6'd63;

  typedef enum logic [1:0] {
    KIND_UNKNOWN  = 2'b00,
    KIND_FREE     = 2'b01,
    KIND_OBSTACLE = 2'b10,
    KIND_PATH     = 2'b11
  } cell_kind_t;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } buf_state_t;

  // y*40 + x built from shifts so no multiplier is inferred
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
    logic [ADDR_W-1:0] xw;
    logic [ADDR_W-1:0] yw;
    xw = {{(ADDR_W-COORD_W){1'b0}}, x};
    yw = {{(ADDR_W-COORD_W){1'b0}}, y};
    return (yw << 5) + (yw << 3) + xw;
  endfunction

endpackage

// File: rtl/grid_cell_ram.sv
// grid_cell_ram
// 1600x2 cell-state memory. Port A is the write port together with its own
// synchronous read used for read-before-write checks; port B is the display
// read port. All reads are read-first: a read and a write to the same address
// on the same edge return the previous contents. Contents are not reset.
// Ports:
//   sync             clock, rising edge
//   we/waddr/wdata   port A write
//   raddr_a/rdata_a  port A synchronous read (read-before-write)
//   raddr_b/rdata_b  port B synchronous read (display)
module grid_cell_ram
  import astar_pkg::*;
#(
  parameter int DEPTH = CELL_COUNT
) (
  input  logic              sync,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [1:0]        wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [1:0]        rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [1:0]        rdata_b
);

  logic [1:0] mem [DEPTH];

  // Non-blocking write and reads on the same edge give read-first behaviour
  always_ff @(posedge sync) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_a <= mem[raddr_a];
    rdata_b <= mem[raddr_b];
  end

endmodule

// File: rtl/grid_cell_buffer.sv
// grid_cell_buffer
// Display stage of the A* path-finder. Holds the 40x40 cell-state map written
// by the search core and reads it back for the VGA pixel stream.
// Optional feature: define GRID_PATH_COUNT_EN to add the path_count output.
// Ports:
//   sync, reset                 clock and asynchronous active-low reset
//   clr_start, clr_busy         map clear request / sweep in progress
//   wr_valid, wr_ready          cell write handshake
//   wr_x, wr_y, wr_kind         cell coordinate and new kind
//   wr_err                      sticky rejected-write flag
//   pix_valid, pix_x, pix_y     pixel coordinate from the timing generator
//   gridx, gridy                cell of the pixel two cycles earlier (63 outside)
//   draw_grid/obstacle/path/unknown  display flags
//   path_count                  number of path cells (GRID_PATH_COUNT_EN only)
module grid_cell_buffer
  import astar_pkg::ADDR_W, astar_pkg::COORD_W, astar_pkg::COORD_OUTSIDE,
         astar_pkg::cell_kind_t, astar_pkg::KIND_UNKNOWN, astar_pkg::KIND_OBSTACLE,
         astar_pkg::KIND_PATH, astar_pkg::buf_state_t, astar_pkg::CLEAR,
         astar_pkg::IDLE, astar_pkg::cell_addr;
#(
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 40,
  parameter int CELL_SHIFT = 3,
  parameter int X_OFFSET   = 160,
  parameter int Y_OFFSET   = 80
) (
  input  logic       sync,
  input  logic       reset,
  input  logic       clr_start,
  output logic       clr_busy,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [5:0] wr_x,
  input  logic [5:0] wr_y,
  input  logic [1:0] wr_kind,
  output logic       wr_err,
  input  logic       pix_valid,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic [5:0] gridx,
  output logic [5:0] gridy,
  output logic       draw_grid,
  output logic       draw_obstacle,
  output logic       draw_path,
  output logic       draw_unknown
`ifdef GRID_PATH_COUNT_EN
  ,
  output logic [10:0] path_count
`endif
);

  localparam logic [9:0] X_LO = 10'(X_OFFSET);
  localparam logic [9:0] X_HI = 10'(X_OFFSET + (GRID_W << CELL_SHIFT));
  localparam logic [9:0] Y_LO = 10'(Y_OFFSET);
  localparam logic [9:0] Y_HI = 10'(Y_OFFSET + (GRID_H << CELL_SHIFT));
  localparam logic [COORD_W-1:0] X_LIMIT   = COORD_W'(GRID_W);
  localparam logic [COORD_W-1:0] Y_LIMIT   = COORD_W'(GRID_H);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(GRID_W * GRID_H - 1);

  buf_state_t        state;
  logic [ADDR_W-1:0] clr_addr;

  logic              accept;
  logic              acc_in_range;
  logic [ADDR_W-1:0] acc_addr;
  logic              pend_valid;
  logic              pend_in_range;
  logic [ADDR_W-1:0] pend_addr;
  cell_kind_t        pend_kind;
  logic              byp_valid;
  logic [ADDR_W-1:0] byp_addr;
  cell_kind_t        byp_kind;
  cell_kind_t        old_kind;
  logic              decide;
  logic              reject;
  logic              commit;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [1:0]        ram_wdata;
  logic [1:0]        rd_a;
  logic [1:0]        rd_b;

  logic [9:0]         dx;
  logic [9:0]         dy;
  logic [COORD_W-1:0] pix_gx;
  logic [COORD_W-1:0] pix_gy;
  logic               in_region;
  logic               on_boundary;
  logic               s1_in;
  logic               s1_bnd;
  logic [COORD_W-1:0] s1_gx;
  logic [COORD_W-1:0] s1_gy;
  logic [ADDR_W-1:0]  s1_addr;
  logic               s2_in;
  logic               s2_bnd;
  logic               show;
  logic               cell_on;
  cell_kind_t         disp_kind;

  // Out-of-range writes read address 0 so the RAM is never indexed past its end
  assign accept       = wr_valid && wr_ready;
  assign acc_in_range = (wr_x < X_LIMIT) && (wr_y < Y_LIMIT);
  assign acc_addr     = acc_in_range ? cell_addr(wr_x, wr_y) : '0;

  // The previous cycle's committed write is not yet visible in rd_a, so a
  // back-to-back write to the same cell takes the kind from the bypass.
  // A pending write accepted on the clr_start edge is dropped: the sweep wins.
  assign old_kind = (byp_valid && (byp_addr == pend_addr)) ? byp_kind : cell_kind_t'(rd_a);
  assign decide   = pend_valid && (state == IDLE);
  assign reject   = decide && (!pend_in_range ||
                               ((pend_kind == KIND_PATH) && (old_kind == KIND_OBSTACLE)));
  assign commit   = decide && !reject;

  // The sweep owns the write port during CLEAR; otherwise committed writes use it
  always_comb begin
    ram_we    = commit;
    ram_waddr = pend_addr;
    ram_wdata = pend_kind;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
      ram_wdata = KIND_UNKNOWN;
    end
  end

  grid_cell_ram u_ram (
    .sync    (sync),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (acc_addr),
    .rdata_a (rd_a),
    .raddr_b (s1_addr),
    .rdata_b (rd_b)
  );

  // Clear sweep / idle control with registered handshake outputs
  always_ff @(posedge sync or negedge reset) begin
    if (!reset) begin
      state    <= CLEAR;
      clr_addr <= '0;
      clr_busy <= 1'b1;
      wr_ready <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            state    <= IDLE;
            clr_addr <= '0;
            clr_busy <= 1'b0;
            wr_ready <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            clr_addr <= '0;
            clr_busy <= 1'b1;
            wr_ready <= 1'b0;
            wr_err   <= 1'b0;
          end else if (reject) begin
            wr_err <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Accepted write waits one cycle for its read-before-write data
  always_ff @(posedge sync or negedge reset) begin
    if (!reset) begin
      pend_valid    <= 1'b0;
      pend_in_range <= 1'b0;
      pend_addr     <= '0;
      pend_kind     <= KIND_UNKNOWN;
      byp_valid     <= 1'b0;
      byp_addr      <= '0;
      byp_kind      <= KIND_UNKNOWN;
    end else begin
      pend_valid    <= accept;
      pend_in_range <= acc_in_range;
      pend_addr     <= acc_addr;
      pend_kind     <= cell_kind_t'(wr_kind);
      byp_valid     <= commit;
      byp_addr      <= pend_addr;
      byp_kind      <= pend_kind;
    end
  end

  assign dx          = pix_x - X_LO;
  assign dy          = pix_y - Y_LO;
  assign pix_gx      = COORD_W'(dx >> CELL_SHIFT);
  assign pix_gy      = COORD_W'(dy >> CELL_SHIFT);
  assign in_region   = pix_valid && (pix_x >= X_LO) && (pix_x < X_HI) &&
                       (pix_y >= Y_LO) && (pix_y < Y_HI);
  assign on_boundary = (dx[CELL_SHIFT-1:0] == '0) || (dy[CELL_SHIFT-1:0] == '0);

  // Two-stage display pipeline; the RAM output register is stage 2's cell data
  always_ff @(posedge sync or negedge reset) begin
    if (!reset) begin
      s1_in   <= 1'b0;
      s1_bnd  <= 1'b0;
      s1_gx   <= COORD_OUTSIDE;
      s1_gy   <= COORD_OUTSIDE;
      s1_addr <= '0;
      s2_in   <= 1'b0;
      s2_bnd  <= 1'b0;
      gridx   <= COORD_OUTSIDE;
      gridy   <= COORD_OUTSIDE;
    end else begin
      s1_in   <= in_region;
      s1_bnd  <= on_boundary;
      s1_gx   <= in_region ? pix_gx : COORD_OUTSIDE;
      s1_gy   <= in_region ? pix_gy : COORD_OUTSIDE;
      s1_addr <= in_region ? cell_addr(pix_gx, pix_gy) : '0;
      s2_in   <= s1_in;
      s2_bnd  <= s1_bnd;
      gridx   <= s1_gx;
      gridy   <= s1_gy;
    end
  end

  assign disp_kind     = cell_kind_t'(rd_b);
  assign show          = !clr_busy && s2_in;
  assign cell_on       = show && !s2_bnd;
  assign draw_grid     = show && s2_bnd;
  assign draw_unknown  = cell_on && (disp_kind == KIND_UNKNOWN);
  assign draw_obstacle = cell_on && (disp_kind == KIND_OBSTACLE);
  assign draw_path     = cell_on && (disp_kind == KIND_PATH);

`ifdef GRID_PATH_COUNT_EN
  // Tracks path cells from the same old/new kinds the write check uses
  always_ff @(posedge sync or negedge reset) begin
    if (!reset) begin
      path_count <= '0;
    end else if (state == CLEAR) begin
      path_count <= '0;
    end else if (commit) begin
      if ((pend_kind == KIND_PATH) && (old_kind != KIND_PATH)) begin
        path_count <= path_count + 1'b1;
      end else if ((pend_kind != KIND_PATH) && (old_kind == KIND_PATH)) begin
        path_count <= path_count - 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_grid_cell_buffer.sv
// tb_grid_cell_buffer
// Directed bench for grid_cell_buffer: clear sweeps, cell writes with their
// rejection rules and the two-cycle display pipeline. Expected display
// results are queued when a pixel is driven and popped when it emerges.
module tb_grid_cell_buffer;

  logic       sync = 1'b0;
  logic       reset = 1'b0;
  logic       clr_start = 1'b0;
  logic       clr_busy;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [5:0] wr_x = '0;
  logic [5:0] wr_y = '0;
  logic [1:0] wr_kind = '0;
  logic       wr_err;
  logic       pix_valid = 1'b0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic [5:0] gridx;
  logic [5:0] gridy;
  logic       draw_grid;
  logic       draw_obstacle;
  logic       draw_path;
  logic       draw_unknown;
`ifdef GRID_PATH_COUNT_EN
  logic [10:0] path_count;
`endif

  typedef struct packed {
    logic       grid;
    logic       obstacle;
    logic       path;
    logic       unknown;
    logic [5:0] gx;
    logic [5:0] gy;
  } disp_t;

  disp_t expQ[$];
  int    compared = 0;
  int    mismatched = 0;

  grid_cell_buffer dut (
    .sync          (sync),
    .reset         (reset),
    .clr_start     (clr_start),
    .clr_busy      (clr_busy),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_x          (wr_x),
    .wr_y          (wr_y),
    .wr_kind       (wr_kind),
    .wr_err        (wr_err),
    .pix_valid     (pix_valid),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .gridx         (gridx),
    .gridy         (gridy),
    .draw_grid     (draw_grid),
    .draw_obstacle (draw_obstacle),
    .draw_path     (draw_path),
    .draw_unknown  (draw_unknown)
`ifdef GRID_PATH_COUNT_EN
    ,
    .path_count    (path_count)
`endif
  );

  // Free-running 10 ns clock
  always #5 sync = ~sync;

  function automatic disp_t mkDisp(input logic g, input logic o, input logic p,
                                   input logic u, input logic [5:0] gx,
                                   input logic [5:0] gy);
    disp_t d;
    d.grid     = g;
    d.obstacle = o;
    d.path     = p;
    d.unknown  = u;
    d.gx       = gx;
    d.gy       = gy;
    return d;
  endfunction

  // Single comparison point: counts it and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one pixel for one cycle, then compare the outputs two cycles later
  task automatic applyStimulus(input string tag, input logic [9:0] x, input logic [9:0] y,
                               input logic valid, input disp_t exp);
    disp_t got;
    disp_t want;
    pix_x     = x;
    pix_y     = y;
    pix_valid = valid;
    expQ.push_back(exp);
    @(posedge sync);
    @(negedge sync);
    pix_valid = 1'b0;
    wr_valid  = 1'b0;
    @(posedge sync);
    @(negedge sync);
    got  = {draw_grid, draw_obstacle, draw_path, draw_unknown, gridx, gridy};
    want = expQ.pop_front();
    checkOutput(tag, 32'(got), 32'(want));
  endtask

  // Present one write for one cycle; consecutive calls give back-to-back writes
  task automatic writeCell(input logic [5:0] x, input logic [5:0] y, input logic [1:0] kind);
    wr_x     = x;
    wr_y     = y;
    wr_kind  = kind;
    wr_valid = 1'b1;
    @(negedge sync);
    wr_valid = 1'b0;
  endtask

  task automatic pulseClear();
    clr_start = 1'b1;
    @(negedge sync);
    clr_start = 1'b0;
  endtask

  // Count sweep cycles with a bounded wait while a region pixel is shown;
  // optionally pulse clr_start mid-sweep, which must have no effect
  task automatic waitClear(input string tag, input int pulseAt);
    int cycles;
    bit drawSeen;
    bit readyBad;
    cycles    = 0;
    drawSeen  = 1'b0;
    readyBad  = 1'b0;
    pix_x     = 10'd161;
    pix_y     = 10'd81;
    pix_valid = 1'b1;
    while (clr_busy === 1'b1 && cycles < 2000) begin
      @(negedge sync);
      cycles++;
      clr_start = (cycles == pulseAt);
      if (clr_busy === 1'b1) begin
        if ({draw_grid, draw_obstacle, draw_path, draw_unknown} !== 4'b0000) drawSeen = 1'b1;
        if (wr_ready !== 1'b0) readyBad = 1'b1;
      end
    end
    clr_start = 1'b0;
    pix_valid = 1'b0;
    checkOutput({tag, " sweep cycles"}, 32'(cycles), 32'd1600);
    checkOutput({tag, " draw during sweep"}, 32'(drawSeen), 32'd0);
    checkOutput({tag, " wr_ready during sweep"}, 32'(readyBad), 32'd0);
    checkOutput({tag, " busy/ready after sweep"}, 32'({clr_busy, wr_ready}), 32'b01);
  endtask

  // Directed sequence
  initial begin
    $display("[TB] grid_cell_buffer bench starting");

    repeat (3) @(negedge sync);
    checkOutput("reset clr_busy/wr_ready/wr_err", 32'({clr_busy, wr_ready, wr_err}), 32'b100);
    checkOutput("reset gridx/gridy", 32'({gridx, gridy}), 32'hFFF);
    checkOutput("reset draw flags",
                32'({draw_grid, draw_obstacle, draw_path, draw_unknown}), 32'd0);

    reset = 1'b1;
    waitClear("reset release", 0);

    writeCell(6'd0, 6'd0, 2'b10);
    applyStimulus("obstacle (0,0)", 10'd161, 10'd81, 1'b1, mkDisp(0, 1, 0, 0, 6'd0, 6'd0));
    writeCell(6'd3, 6'd2, 2'b11);
    applyStimulus("path (3,2)", 10'd188, 10'd100, 1'b1, mkDisp(0, 0, 1, 0, 6'd3, 6'd2));
    writeCell(6'd6, 6'd0, 2'b01);
    applyStimulus("free (6,0)", 10'd210, 10'd83, 1'b1, mkDisp(0, 0, 0, 0, 6'd6, 6'd0));
    writeCell(6'd39, 6'd39, 2'b10);
    applyStimulus("obstacle (39,39)", 10'd479, 10'd399, 1'b1, mkDisp(0, 1, 0, 0, 6'd39, 6'd39));
    checkOutput("wr_err after legal writes", 32'(wr_err), 32'd0);

    writeCell(6'd5, 6'd7, 2'b10);
    writeCell(6'd5, 6'd7, 2'b11);
    repeat (2) @(negedge sync);
    checkOutput("wr_err path onto obstacle", 32'(wr_err), 32'd1);
    applyStimulus("obstacle kept (5,7)", 10'd205, 10'd139, 1'b1, mkDisp(0, 1, 0, 0, 6'd5, 6'd7));

    pulseClear();
    checkOutput("wr_err cleared by clr_start", 32'(wr_err), 32'd0);
    waitClear("clr_start", 500);
    applyStimulus("cleared (0,0)", 10'd161, 10'd81, 1'b1, mkDisp(0, 0, 0, 1, 6'd0, 6'd0));
    applyStimulus("cleared (5,7)", 10'd205, 10'd139, 1'b1, mkDisp(0, 0, 0, 1, 6'd5, 6'd7));

    writeCell(6'd40, 6'd0, 2'b11);
    repeat (2) @(negedge sync);
    checkOutput("wr_err x=40", 32'(wr_err), 32'd1);
    applyStimulus("x=40 leaves (0,1)", 10'd161, 10'd89, 1'b1, mkDisp(0, 0, 0, 1, 6'd0, 6'd1));

    applyStimulus("grid corner", 10'd160, 10'd80, 1'b1, mkDisp(1, 0, 0, 0, 6'd0, 6'd0));
    applyStimulus("grid line x", 10'd168, 10'd85, 1'b1, mkDisp(1, 0, 0, 0, 6'd1, 6'd0));
    applyStimulus("outside left", 10'd100, 10'd100, 1'b1, mkDisp(0, 0, 0, 0, 6'd63, 6'd63));
    applyStimulus("outside right", 10'd480, 10'd100, 1'b1, mkDisp(0, 0, 0, 0, 6'd63, 6'd63));
    applyStimulus("pixel not valid", 10'd161, 10'd81, 1'b0, mkDisp(0, 0, 0, 0, 6'd63, 6'd63));

    // Write and display read of the same cell on the same edge: old data first
    wr_x     = 6'd1;
    wr_y     = 6'd1;
    wr_kind  = 2'b10;
    wr_valid = 1'b1;
    applyStimulus("same-cycle read old", 10'd169, 10'd89, 1'b1, mkDisp(0, 0, 0, 1, 6'd1, 6'd1));
    applyStimulus("written (1,1) visible", 10'd169, 10'd89, 1'b1, mkDisp(0, 1, 0, 0, 6'd1, 6'd1));

    // Reset in the middle of a sweep
    pulseClear();
    pix_x     = 10'd161;
    pix_y     = 10'd81;
    pix_valid = 1'b1;
    repeat (800) @(negedge sync);
    checkOutput("gridx mid-sweep", 32'({gridx, gridy}), 32'h000);
    reset = 1'b0;
    #1;
    checkOutput("mid-sweep reset busy/ready/err", 32'({clr_busy, wr_ready, wr_err}), 32'b100);
    checkOutput("mid-sweep reset gridx/gridy", 32'({gridx, gridy}), 32'hFFF);
    checkOutput("mid-sweep reset draw flags",
                32'({draw_grid, draw_obstacle, draw_path, draw_unknown}), 32'd0);
    repeat (2) @(negedge sync);
    reset = 1'b1;
    waitClear("reset mid-sweep", 0);

    writeCell(6'd0, 6'd0, 2'b11);
    applyStimulus("path after reset", 10'd161, 10'd81, 1'b1, mkDisp(0, 0, 1, 0, 6'd0, 6'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
